serial_sample_player: RTL and testbench
=======================================

# serial_sample_player

Read-side companion of the serial sample store in the genetic-circuit evaluator. It takes the stored per-sample input sequences, expected outputs and valid masks, and plays each sample bit-serially into the candidate circuit. It compares the returned serial output against the expected bits under the valid mask and accumulates a mismatch count, which serves as the fitness score for one evaluation pass.

## Interface
- NUM_SAMPLES, 16, highest sample index; arrays hold NUM_SAMPLES+1 entries of 8 bits.
- CIRCUIT_LATENCY, 1, cycles from driving a bit on oCircuitInput to its response on iCircuitOutput; legal range 1..8.
- ERR_W, $clog2((NUM_SAMPLES+1)*8+1), width of the error counter.

Ports:
- iClock  in  1  single clock; all logic on its rising edge.
- iResetN  in  1  synchronous, active-low reset.
- iStart  in  1  request an evaluation pass; accepted only in IDLE.
- iInputSequences  in  [NUM_SAMPLES:0][7:0]  serial input per sample.
- iExpectedOutputs  in  [NUM_SAMPLES:0][7:0]  expected serial output per sample.
- iValidOutputs  in  [NUM_SAMPLES:0][7:0]  per-bit compare mask; 1 means the bit is checked.
- oCircuitInput  out  1  serial bit to the candidate circuit.
- oCircuitReset  out  1  active-high, one-cycle clear of the candidate circuit before each sample.
- iCircuitOutput  in  1  serial bit from the candidate circuit.
- oBusy  out  1  high while a pass runs.
- oDone  out  1  one-cycle pulse at the end of a pass.
- oSampleIndex  out  32  sample currently being played.
- oErrorCount  out  ERR_W  mismatches in the current or last pass.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- **IDLE**
  - iStart=1 moves to CLEAR and clears oErrorCount and oSampleIndex.
  - oBusy goes high.
- **CLEAR**: one cycle with oCircuitReset=1 and oCircuitInput=0, then SHIFT.
- **SHIFT**
  - Eight cycles.
  - Bit counter k=0..7 drives oCircuitInput = iInputSequences[idx][k], LSB first.
  - Each driven bit pushes (expected[k], valid[k], strobe=1) into the compare pipeline.
- **DRAIN**
  - CIRCUIT_LATENCY cycles with oCircuitInput=0 and no pushes.
  - Then, if idx==NUM_SAMPLES, go to DONE; otherwise idx+1 and go to CLEAR.
- **DONE**: oDone=1 for one cycle, oBusy=0, then IDLE.
- **Compare pipeline**
  - Shift register of depth CIRCUIT_LATENCY.
  - At its tail, strobe & valid & (iCircuitOutput != expected) increments oErrorCount.
  - The counter saturates at all-ones.
- The pipeline is flushed (strobes cleared) at every CLEAR.
- iStart outside IDLE is ignored. The input arrays must be held stable while oBusy=1.
- oErrorCount holds its value after DONE until the next accepted iStart.

## Timing
- Reset values:
  - state=IDLE.
  - oCircuitInput=0, oCircuitReset=0, oBusy=0, oDone=0.
  - oSampleIndex=0, oErrorCount=0.
  - Pipeline strobes are cleared.
- iStart sampled at edge 0 puts CLEAR in the cycle that follows.
- Per sample: 1 + 8 + CIRCUIT_LATENCY cycles.
- oDone is asserted (NUM_SAMPLES+1)*(9+CIRCUIT_LATENCY)+1 cycles after iStart is accepted.
- Reset mid-pass returns everything to reset values immediately. No oDone is produced, and a new iStart is required.
- iStart in the DONE cycle is ignored. It is accepted on the following cycle in IDLE.

## Configuration
- SERIAL_PLAYER_EARLY_ABORT_EN defined:
  - Adds input iErrorLimit [ERR_W-1:0] and output oAborted (reset 0).
  - When the counter reaches iErrorLimit (nonzero) in CLEAR, SHIFT or DRAIN, the FSM goes directly to DONE with oAborted=1 alongside oDone.
  - oAborted is cleared on the next accepted iStart.
- SERIAL_PLAYER_EARLY_ABORT_EN undefined: no extra ports, and every pass plays all samples.

## Structure
- Shared package serial_eval_pkg:
  - State enum.
  - SEQ_BITS=8.
  - Default NUM_SAMPLES.
- Sub-module serial_compare_pipe holds the latency delay line, the mask compare and the saturating error counter. The top level holds the FSM, bit counter and sample index.

## Test plan
All scenarios use NUM_SAMPLES=1 and CIRCUIT_LATENCY=1. The candidate circuit is a single register, either buffer or inverter.
- Buffer circuit, inputs 0xA5/0x3C, expected equal to inputs, valid 0xFF/0xFF -> oErrorCount=0, oDone exactly 21 cycles after iStart.
- Inverter circuit, same data -> oErrorCount=16.
- Inverter circuit, valid 0x0F/0x00 -> oErrorCount=4.
- Input 0x01 for sample 0 -> oCircuitInput high only on the first SHIFT cycle; oCircuitReset high on cycles 1 and 11 after iStart.
- iStart pulsed at cycle 5 -> ignored. iResetN low at cycle 10 -> oBusy=0, oErrorCount=0 next cycle, no oDone. A later iStart completes a normal pass.
- With SERIAL_PLAYER_EARLY_ABORT_EN, inverter circuit, iErrorLimit=3 -> oDone and oAborted together, oErrorCount=3, oSampleIndex=0.

Source files
------------

// File: rtl/serial_eval_pkg.sv
// Shared types and constants for the serial sample store / player pair.
package serial_eval_pkg;

  localparam int SEQ_BITS            = 8;
  localparam int DEFAULT_NUM_SAMPLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } PlayerState;

endpackage

// File: rtl/serial_compare_pipe.sv
// Latency-matching delay line for expected/valid bits, masked compare against the
// returned circuit bit, and the saturating mismatch counter.
module serial_compare_pipe #(
  parameter int LATENCY = 1,
  parameter int ERR_W   = 8
) (
  input  logic             iClock,
  input  logic             iResetN,
  input  logic             iClearCount,
  input  logic             iFlush,
  input  logic             iCountEn,
  input  logic             iPush,
  input  logic             iExpected,
  input  logic             iValid,
  input  logic             iCircuitOutput,
  output logic [ERR_W-1:0] oErrorCount,
  output logic [ERR_W-1:0] oErrorNext
);

  logic [LATENCY-1:0] strobeLine;
  logic [LATENCY-1:0] expectedLine;
  logic [LATENCY-1:0] validLine;
  logic               mismatch;

  always_ff @(posedge iClock) begin
    if (!iResetN || iFlush) begin
      strobeLine   <= '0;
      expectedLine <= '0;
      validLine    <= '0;
    end else begin
      strobeLine[0]   <= iPush;
      expectedLine[0] <= iExpected;
      validLine[0]    <= iValid;
      for (int i = 1; i < LATENCY; i++) begin
        strobeLine[i]   <= strobeLine[i-1];
        expectedLine[i] <= expectedLine[i-1];
        validLine[i]    <= validLine[i-1];
      end
    end
  end

  assign mismatch = iCountEn && strobeLine[LATENCY-1] && validLine[LATENCY-1]
                    && (iCircuitOutput != expectedLine[LATENCY-1]);

  // The next count is exposed so the player can react in the same cycle it is reached.
  always_comb begin
    oErrorNext = oErrorCount;
    if (iClearCount) begin
      oErrorNext = '0;
    end else if (mismatch && (oErrorCount != '1)) begin
      oErrorNext = oErrorCount + 1'b1;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      oErrorCount <= '0;
    end else begin
      oErrorCount <= oErrorNext;
    end
  end

endmodule

// File: rtl/serial_sample_player.sv
// Plays stored samples bit-serially into the candidate circuit and counts masked mismatches.
// Optional early abort on an error limit is enabled by defining SERIAL_PLAYER_EARLY_ABORT_EN.
module serial_sample_player
  import serial_eval_pkg::*;
#(
  parameter int NUM_SAMPLES     = DEFAULT_NUM_SAMPLES,
  parameter int CIRCUIT_LATENCY = 1,
  parameter int ERR_W           = $clog2((NUM_SAMPLES + 1) * SEQ_BITS + 1)
) (
  input  logic                               iClock,
  input  logic                               iResetN,
  input  logic                               iStart,
  input  logic [NUM_SAMPLES:0][SEQ_BITS-1:0] iInputSequences,
  input  logic [NUM_SAMPLES:0][SEQ_BITS-1:0] iExpectedOutputs,
  input  logic [NUM_SAMPLES:0][SEQ_BITS-1:0] iValidOutputs,
  output logic                               oCircuitInput,
  output logic                               oCircuitReset,
  input  logic                               iCircuitOutput,
  output logic                               oBusy,
  output logic                               oDone,
  output logic [31:0]                        oSampleIndex,
`ifdef SERIAL_PLAYER_EARLY_ABORT_EN
  input  logic [ERR_W-1:0]                   iErrorLimit,
  output logic                               oAborted,
`endif
  output logic [ERR_W-1:0]                   oErrorCount
);

  localparam int IDX_W   = (NUM_SAMPLES > 0) ? $clog2(NUM_SAMPLES + 1) : 1;
  localparam int BIT_W   = $clog2(SEQ_BITS);
  localparam int DRAIN_W = 4;

  PlayerState        state;
  PlayerState        stateNext;
  logic [IDX_W-1:0]  sampleIdx;
  logic [BIT_W-1:0]  bitCount;
  logic [DRAIN_W-1:0] drainCount;
  logic              startAccept;
  logic              lastBit;
  logic              drainDone;
  logic              lastSample;
  logic              active;
  logic              abortHit;
  logic              push;
  logic [ERR_W-1:0]  errorNext;

  assign startAccept = (state == IDLE) && iStart;
  assign lastBit     = (bitCount == BIT_W'(SEQ_BITS - 1));
  assign drainDone   = (drainCount == DRAIN_W'(CIRCUIT_LATENCY - 1));
  assign lastSample  = (sampleIdx == IDX_W'(NUM_SAMPLES));
  assign active      = (state == CLEAR) || (state == SHIFT) || (state == DRAIN);

`ifdef SERIAL_PLAYER_EARLY_ABORT_EN
  assign abortHit = active && (iErrorLimit != '0) && (errorNext >= iErrorLimit);
`else
  assign abortHit = 1'b0;
`endif

  always_comb begin
    stateNext     = state;
    oCircuitInput = 1'b0;
    oCircuitReset = 1'b0;
    oBusy         = active;
    oDone         = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE:  if (iStart) stateNext = CLEAR;
      CLEAR: begin
        oCircuitReset = 1'b1;
        stateNext     = SHIFT;
      end
      SHIFT: begin
        oCircuitInput = iInputSequences[sampleIdx][bitCount];
        push          = 1'b1;
        if (lastBit) stateNext = DRAIN;
      end
      DRAIN: if (drainDone) stateNext = lastSample ? DONE : CLEAR;
      DONE: begin
        oDone     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (abortHit) stateNext = DONE;
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      state      <= IDLE;
      sampleIdx  <= '0;
      bitCount   <= '0;
      drainCount <= '0;
    end else begin
      state      <= stateNext;
      bitCount   <= (state == SHIFT) ? bitCount + 1'b1 : '0;
      drainCount <= (state == DRAIN) ? drainCount + 1'b1 : '0;
      if (startAccept) begin
        sampleIdx <= '0;
      end else if ((state == DRAIN) && drainDone && !lastSample && !abortHit) begin
        sampleIdx <= sampleIdx + 1'b1;
      end
    end
  end

  assign oSampleIndex = 32'(sampleIdx);

`ifdef SERIAL_PLAYER_EARLY_ABORT_EN
  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      oAborted <= 1'b0;
    end else if (startAccept) begin
      oAborted <= 1'b0;
    end else if (abortHit) begin
      oAborted <= 1'b1;
    end
  end
`endif

  // Counting is gated to the active states so bits still in flight at an abort are dropped.
  serial_compare_pipe #(
    .LATENCY (CIRCUIT_LATENCY),
    .ERR_W   (ERR_W)
  ) comparePipe (
    .iClock         (iClock),
    .iResetN        (iResetN),
    .iClearCount    (startAccept),
    .iFlush         ((state == CLEAR) || (state == DONE)),
    .iCountEn       (active),
    .iPush          (push),
    .iExpected      (iExpectedOutputs[sampleIdx][bitCount]),
    .iValid         (iValidOutputs[sampleIdx][bitCount]),
    .iCircuitOutput (iCircuitOutput),
    .oErrorCount    (oErrorCount),
    .oErrorNext     (errorNext)
  );

endmodule

// File: tb/tb_serial_sample_player.sv
// Scoreboard bench for serial_sample_player with a one-register buffer/inverter as candidate circuit.
module tb_serial_sample_player;
  import serial_eval_pkg::*;

  localparam int NS  = 1;
  localparam int LAT = 1;
  localparam int EW  = $clog2((NS + 1) * SEQ_BITS + 1);
  localparam int PER = 9 + LAT;

  logic                      clock = 1'b0;
  logic                      resetN = 1'b0;
  logic                      start = 1'b0;
  logic [NS:0][SEQ_BITS-1:0] inputSeq = '0;
  logic [NS:0][SEQ_BITS-1:0] expectedSeq = '0;
  logic [NS:0][SEQ_BITS-1:0] validSeq = '0;
  logic                      circuitInput;
  logic                      circuitReset;
  logic                      circuitOutput = 1'b0;
  logic                      busy;
  logic                      done;
  logic [31:0]               sampleIndex;
  logic [EW-1:0]             errorCount;
  logic                      invertMode = 1'b0;
`ifdef SERIAL_PLAYER_EARLY_ABORT_EN
  logic [EW-1:0]             errorLimit = '0;
  logic                      aborted;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int errs;
    int latency;
    int sampleIdx;
  } ExpResult;
  ExpResult scoreboard[$];

  serial_sample_player #(
    .NUM_SAMPLES     (NS),
    .CIRCUIT_LATENCY (LAT)
  ) dut (
    .iClock           (clock),
    .iResetN          (resetN),
    .iStart           (start),
    .iInputSequences  (inputSeq),
    .iExpectedOutputs (expectedSeq),
    .iValidOutputs    (validSeq),
    .oCircuitInput    (circuitInput),
    .oCircuitReset    (circuitReset),
    .iCircuitOutput   (circuitOutput),
    .oBusy            (busy),
    .oDone            (done),
    .oSampleIndex     (sampleIndex),
`ifdef SERIAL_PLAYER_EARLY_ABORT_EN
    .iErrorLimit      (errorLimit),
    .oAborted         (aborted),
`endif
    .oErrorCount      (errorCount)
  );

  always #5 clock = ~clock;

  // Candidate circuit: one register, buffer or inverter, cleared by the player.
  always @(posedge clock) circuitOutput <= circuitReset ? 1'b0 : (circuitInput ^ invertMode);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelErrors(input logic inv, input int bitLimit);
    int n = 0;
    for (int s = 0; s <= NS; s++)
      for (int b = 0; b < SEQ_BITS; b++)
        if ((s * SEQ_BITS + b) < bitLimit && validSeq[s][b] && ((inputSeq[s][b] ^ inv) != expectedSeq[s][b]))
          n++;
    return n;
  endfunction

  task automatic applyStimulus(input logic [7:0] in0, input logic [7:0] in1,
                               input logic [7:0] exp0, input logic [7:0] exp1,
                               input logic [7:0] val0, input logic [7:0] val1, input logic inv);
    ExpResult r;
    ExpResult got;
    int waited;
    int phase;
    int s;
    logic expIn;
    @(negedge clock);
    inputSeq    = {in1, in0};
    expectedSeq = {exp1, exp0};
    validSeq    = {val1, val0};
    invertMode  = inv;
    r.errs      = modelErrors(inv, (NS + 1) * SEQ_BITS);
    r.latency   = (NS + 1) * PER + 1;
    r.sampleIdx = NS;
    scoreboard.push_back(r);
    start = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clock);
      start = 1'b0;
      waited++;
      if (waited <= (NS + 1) * PER) begin
        phase = (waited - 1) % PER;
        s     = (waited - 1) / PER;
        expIn = (phase >= 1 && phase <= SEQ_BITS) ? inputSeq[s][phase-1] : 1'b0;
        checkOutput("circuitInput", 32'(circuitInput), 32'(expIn));
        checkOutput("circuitReset", 32'(circuitReset), 32'(phase == 0));
        checkOutput("busy", 32'(busy), 32'd1);
      end
      if (done) begin
        got = scoreboard.pop_front();
        checkOutput("errorCount", 32'(errorCount), 32'(got.errs));
        checkOutput("doneLatency", 32'(waited), 32'(got.latency));
        checkOutput("sampleIndex", sampleIndex, 32'(got.sampleIdx));
        checkOutput("busyInDone", 32'(busy), 32'd0);
        break;
      end
      if (waited >= 200) begin
        void'(scoreboard.pop_front());
        checkOutput("doneTimeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    logic [EW-1:0] heldCount;
    int doneSeen;
    int expMid;
    int waited;

    repeat (3) @(negedge clock);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstCircuitInput", 32'(circuitInput), 32'd0);
    checkOutput("rstCircuitReset", 32'(circuitReset), 32'd0);
    checkOutput("rstSampleIndex", sampleIndex, 32'd0);
    checkOutput("rstErrorCount", 32'(errorCount), 32'd0);
    resetN = 1'b1;

    $display("[TB] buffer circuit, matching data");
    applyStimulus(8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hFF, 8'hFF, 1'b0);
    heldCount = errorCount;
    repeat (2) @(negedge clock);
    checkOutput("errorHold", 32'(errorCount), 32'(heldCount));

    $display("[TB] inverter circuit, full mask");
    applyStimulus(8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clock);
    checkOutput("errorHoldInv", 32'(errorCount), 32'd16);

    $display("[TB] inverter circuit, partial mask");
    applyStimulus(8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h0F, 8'h00, 1'b1);

    $display("[TB] single-bit input pattern");
    applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF, 1'b0);

    // iStart held through the DONE cycle is only taken once IDLE is reached.
    start = 1'b1;
    @(negedge clock);
    checkOutput("startInDoneIgnored", 32'(busy), 32'd0);
    @(negedge clock);
    start = 1'b0;
    checkOutput("startAfterDoneBusy", 32'(busy), 32'd1);
    checkOutput("startAfterDoneClear", 32'(circuitReset), 32'd1);
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    checkOutput("resetAfterRestart", 32'(busy), 32'd0);

    $display("[TB] ignored start and mid-pass reset");
    inputSeq    = {8'h3C, 8'hA5};
    expectedSeq = {8'h3C, 8'hA5};
    validSeq    = {8'hFF, 8'hFF};
    invertMode  = 1'b1;
    expMid      = modelErrors(1'b1, 7);
    start = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clock);
      start = (cyc == 5);
      if (cyc == 6) begin
        checkOutput("midStartCircuitReset", 32'(circuitReset), 32'd0);
        checkOutput("midStartBusy", 32'(busy), 32'd1);
        checkOutput("midStartIndex", sampleIndex, 32'd0);
      end
      if (cyc == 10) begin
        checkOutput("preResetCount", 32'(errorCount), 32'(expMid));
        resetN = 1'b0;
      end
      if (cyc == 11) begin
        checkOutput("postResetBusy", 32'(busy), 32'd0);
        checkOutput("postResetCount", 32'(errorCount), 32'd0);
        checkOutput("postResetDone", 32'(done), 32'd0);
        resetN = 1'b1;
      end
    end
    doneSeen = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clock);
      if (done || busy) doneSeen++;
    end
    checkOutput("noActivityAfterReset", 32'(doneSeen), 32'd0);

    $display("[TB] normal pass after reset");
    applyStimulus(8'h5A, 8'hC3, 8'h5A, 8'hC3, 8'hFF, 8'hFF, 1'b0);

`ifdef SERIAL_PLAYER_EARLY_ABORT_EN
    $display("[TB] early abort at limit 3");
    @(negedge clock);
    inputSeq    = {8'h3C, 8'hA5};
    expectedSeq = {8'h3C, 8'hA5};
    validSeq    = {8'hFF, 8'hFF};
    invertMode  = 1'b1;
    errorLimit  = EW'(3);
    start = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clock);
      start = 1'b0;
      waited++;
      if (done) begin
        checkOutput("abortFlag", 32'(aborted), 32'd1);
        checkOutput("abortCount", 32'(errorCount), 32'd3);
        checkOutput("abortIndex", sampleIndex, 32'd0);
        break;
      end
      if (waited >= 200) begin
        checkOutput("abortTimeout", 32'd0, 32'd1);
        break;
      end
    end
    errorLimit = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
